// File: rtl/peripheral_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_pkg
// Shared constants and types for the memory-mapped peripheral subsystem.
//   *_INT_IDX        : interrupt line index of each peripheral (wiring source
//                      of truth for irq_req_i / irq_ret_o bit positions)
//   IRQ_N_SRC        : number of interrupt sources handled by the controller
//   IRQ_CAUSE_BASE   : mcause value of source 0 (interrupt bit | 16)
//   irq_ctrl_state_t : interrupt controller FSM states
// ---------------------------------------------------------------------------
package peripheral_pkg;

  localparam int SW_INT_IDX      = 0;
  localparam int PS2_INT_IDX     = 1;
  localparam int UART_RX_INT_IDX = 2;
  localparam int TIMER_INT_IDX   = 3;

  localparam int          IRQ_N_SRC      = 16;
  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    RET     = 2'd3
  } irq_ctrl_state_t;

  // Index width that stays legal for a single source.
  function automatic int irq_idx_width(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_select.sv
// ---------------------------------------------------------------------------
// irq_prio_select
// Combinational circular find-first: starting at index `start`, returns the
// first set bit of `req`, wrapping past N_SRC-1 back to 0.
//   req   in  N_SRC : candidate vector
//   start in  IW    : first index examined (values >= N_SRC treated as 0)
//   valid out 1     : any bit of req set
//   idx   out IW    : winning index (0 when !valid)
// ---------------------------------------------------------------------------
module irq_prio_select
  import peripheral_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC,
  parameter int IW    = irq_idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  always_comb begin
    int base;
    int cand;
    logic [IW-1:0] cand_idx;
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    base     = (int'(start) < N_SRC) ? int'(start) : 0;
    // Walk offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore wins.
    for (int off = N_SRC - 1; off >= 0; off--) begin
      cand = base + off;
      if (cand >= N_SRC) begin
        cand = cand - N_SRC;
      end
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/periph_irq_controller.sv
// ---------------------------------------------------------------------------
// periph_irq_controller
// Funnels up to N_SRC level-sensitive peripheral interrupt requests into the
// single machine-external interrupt of the core, presents the mcause of the
// selected source, holds it through trap entry / handler / mret, then pulses
// the per-source return line so the peripheral can drop its request.
//
// Ports:
//   clk_i          in  1      system clock
//   rst_i          in  1      asynchronous active-high reset
//   irq_req_i      in  N_SRC  level requests (bits at *_INT_IDX)
//   mie_i          in  N_SRC  per-source enables (mie[16+:N_SRC])
//   mstatus_mie_i  in  1      global interrupt enable
//   irq_ack_i      in  1      trap-taken pulse from the core
//   mret_i         in  1      mret-executed pulse from the core
//   irq_o          out 1      interrupt request to the core
//   irq_cause_o    out 32     mcause of the selected source, 0 when idle
//   irq_ret_o      out N_SRC  one-hot one-cycle return pulse after mret
//   busy_o         out 1      controller not in IDLE
//
// Build option:
//   PERIPH_IRQ_ROUND_ROBIN_EN  defined   -> round-robin arbitration, search
//                                           starts after the last served source
//                              undefined -> fixed priority, lowest index wins
//
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module periph_irq_controller
  import peripheral_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_SRC-1:0]  irq_req_i,
  input  logic [N_SRC-1:0]  mie_i,
  input  logic              mstatus_mie_i,
  input  logic              irq_ack_i,
  input  logic              mret_i,
  output logic              irq_o,
  output logic [31:0]       irq_cause_o,
  output logic [N_SRC-1:0]  irq_ret_o,
  output logic              busy_o
);

  localparam int IW = irq_idx_width(N_SRC);

  irq_ctrl_state_t  state_reg;
  irq_ctrl_state_t  state_next;
  logic [IW-1:0]    idx_reg;
  logic [N_SRC-1:0] q;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    sel_start;

  assign q = irq_req_i & mie_i & {N_SRC{mstatus_mie_i}};

`ifdef PERIPH_IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_reg;

  // Pointer moves to the source after the one being retired, on RET entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else if (state_reg == SERVICE && mret_i) begin
      if (int'(idx_reg) >= N_SRC - 1) begin
        ptr_reg <= '0;
      end else begin
        ptr_reg <= idx_reg + IW'(1);
      end
    end
  end

  assign sel_start = ptr_reg;
`else
  assign sel_start = '0;
`endif

  irq_prio_select #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_sel (
    .req   (q),
    .start (sel_start),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // State register: the winner is latched only while arbitrating in IDLE,
  // so the cause stays stable through REQ, SERVICE and RET.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && sel_valid) begin
        idx_reg <= sel_idx;
      end
    end
  end

  // Next-state logic. In REQ an ack takes precedence over withdrawal.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_next = SERVICE;
        end else if (!q[idx_reg]) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (mret_i) begin
          state_next = RET;
        end
      end
      RET: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    irq_o       = (state_reg == REQ);
    busy_o      = (state_reg != IDLE);
    irq_cause_o = '0;
    if (state_reg != IDLE) begin
      irq_cause_o = IRQ_CAUSE_BASE + 32'(idx_reg);
    end
  end

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ret
    assign irq_ret_o[gi] = (state_reg == RET) && (idx_reg == IW'(gi));
  end

endmodule

// File: tb/tb_periph_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_periph_irq_controller
// Directed bench for periph_irq_controller (default fixed-priority build).
// Expected causes / return pulses are queued when a request is raised and
// popped when the controller presents the interrupt.
// ---------------------------------------------------------------------------
module tb_periph_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_req;
  logic [15:0] mie;
  logic        mstatus_mie;
  logic        irq_ack;
  logic        mret;
  logic        irq;
  logic [31:0] irq_cause;
  logic [15:0] irq_ret;
  logic        busy;

  typedef struct {
    logic [31:0] cause;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  periph_irq_controller #(.N_SRC(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .irq_req_i     (irq_req),
    .mie_i         (mie),
    .mstatus_mie_i (mstatus_mie),
    .irq_ack_i     (irq_ack),
    .mret_i        (mret),
    .irq_o         (irq),
    .irq_cause_o   (irq_cause),
    .irq_ret_o     (irq_ret),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_src(input int idx);
    exp_t e;
    e.cause = 32'h8000_0010 + 32'(idx);
    e.ret   = 16'(1 << idx);
    exp_q.push_back(e);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_irq_seen"}, 32'(irq), 32'd1);
  endtask

  // Full ack / mret handshake for the currently presented source.
  task automatic service(input string tag, input int idx);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_cause"}, irq_cause, e.cause);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk({tag, "_irq_drop"}, 32'(irq), 32'd0);
      chk({tag, "_cause_held"}, irq_cause, e.cause);
      chk({tag, "_busy_svc"}, 32'(busy), 32'd1);
      mret = 1'b1;
      tick();
      mret = 1'b0;
      chk({tag, "_ret"}, 32'(irq_ret), 32'(e.ret));
      tick();
      chk({tag, "_ret_end"}, 32'(irq_ret), 32'd0);
      chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
      irq_req[idx] = 1'b0;
      $display("txn %s cause=%h ret=%h", tag, e.cause, e.ret);
    end
  endtask

  initial begin
    exp_t e;
    rst         = 1'b1;
    irq_req     = '0;
    mie         = '0;
    mstatus_mie = 1'b0;
    irq_ack     = 1'b0;
    mret        = 1'b0;
    tick();
    tick();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_cause", irq_cause, 32'd0);
    chk("rst_ret", 32'(irq_ret), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single source 2
    irq_req[2]  = 1'b1;
    mie[2]      = 1'b1;
    mstatus_mie = 1'b1;
    expect_src(2);
    chk("t1_irq_pre", 32'(irq), 32'd0);
    tick();
    chk("t1_irq_lat", 32'(irq), 32'd1);
    service("t1", 2);
    tick();

    // Simultaneous 0, 1, 3: fixed priority order
    mie = 16'h000B;
    irq_req = 16'h000B;
    expect_src(0);
    expect_src(1);
    expect_src(3);
    wait_irq("t2a");
    service("t2a", 0);
    wait_irq("t2b");
    service("t2b", 1);
    wait_irq("t2c");
    service("t2c", 3);
    tick();

    // Masked source 3
    mie = '0;
    irq_req[3] = 1'b1;
    tick();
    tick();
    tick();
    chk("t3_masked_irq", 32'(irq), 32'd0);
    chk("t3_masked_busy", 32'(busy), 32'd0);
    mie[3] = 1'b1;
    expect_src(3);
    tick();
    chk("t3_unmask_irq", 32'(irq), 32'd1);
    service("t3", 3);
    tick();

    // Withdrawal in REQ by global disable
    mie = 16'h0002;
    irq_req[1] = 1'b1;
    tick();
    chk("t4_irq", 32'(irq), 32'd1);
    chk("t4_cause", irq_cause, 32'h8000_0011);
    mstatus_mie = 1'b0;
    tick();
    chk("t4_irq_drop", 32'(irq), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ret", 32'(irq_ret), 32'd0);
    tick();
    chk("t4_ret_later", 32'(irq_ret), 32'd0);
    chk("t4_cause_idle", irq_cause, 32'd0);
    irq_req[1]  = 1'b0;
    mstatus_mie = 1'b1;
    tick();

    // No nesting: source 0 requests while 2 is in service
    mie = 16'h0005;
    irq_req[2] = 1'b1;
    expect_src(2);
    tick();
    chk("t5_irq", 32'(irq), 32'd1);
    e = exp_q.pop_front();
    chk("t5_cause", irq_cause, e.cause);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_req[0] = 1'b1;
    expect_src(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_nest_irq", 32'(irq), 32'd0);
      chk("t5_nest_cause", irq_cause, e.cause);
    end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("t5_ret", 32'(irq_ret), 32'(e.ret));
    irq_req[2] = 1'b0;
    tick();
    chk("t5_idle_irq", 32'(irq), 32'd0);
    tick();
    chk("t5_src0_irq", 32'(irq), 32'd1);
    service("t5_src0", 0);
    tick();

    // Asynchronous reset in SERVICE
    mie = 16'h0004;
    irq_req[2] = 1'b1;
    tick();
    chk("t6_irq", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("t6_busy_svc", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_cause", irq_cause, 32'd0);
    chk("t6_rst_ret", 32'(irq_ret), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    irq_req[2] = 1'b0;
    tick();
    rst  = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("t6_mret_ret", 32'(irq_ret), 32'd0);
    chk("t6_mret_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_mret_ret2", 32'(irq_ret), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/periph_irq_controller.md
# periph_irq_controller

Arbitrates the interrupt request lines of the memory-mapped peripherals (switches, PS/2, UART RX, timer, and up to 16 sources in total) into the single machine-external interrupt seen by the RISC-V core. It selects one pending, enabled source and presents its `mcause` value. It holds that source through the trap entry/handler/`mret` handshake, then pulses the per-source return line so the peripheral can drop its request. It sits between the peripheral units and the core's CSR/interrupt logic in the processor system top.

## Interface
- `N_SRC`, default 16: number of interrupt sources, 1..16. Source index `i` maps to `mcause` 16+`i`.
- `clk_i`  in  1: system clock.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `irq_req_i`  in  `N_SRC`: level-sensitive requests; bit indices taken from the `*_INT_IDX` package constants.
- `mie_i`  in  `N_SRC`: per-source enable from CSR `mie[16+:N_SRC]`.
- `mstatus_mie_i`  in  1: global interrupt enable.
- `irq_ack_i`  in  1: one-cycle pulse from the core when it takes the trap.
- `mret_i`  in  1: one-cycle pulse when the core executes `mret`.
- `irq_o`  out  1: interrupt request to the core.
- `irq_cause_o`  out  32: `32'h8000_0000 | (16+idx)` of the selected source. Zero when idle.
- `irq_ret_o`  out  `N_SRC`: one-hot, one-cycle pulse to the serviced source after `mret`.
- `busy_o`  out  1: high in any state other than IDLE.

## Operation
- Qualified vector is `q = irq_req_i & mie_i & {N_SRC{mstatus_mie_i}}`.
- The FSM has four states: IDLE, REQ, SERVICE and RET.
- **IDLE**
  - If `q != 0`: register the winning index `idx`, go to REQ.
  - `irq_cause_o = 0`.
- **REQ**
  - `irq_o = 1`; `irq_cause_o` is stable for the whole state.
  - `irq_ack_i`: go to SERVICE.
  - If the registered source is no longer qualified (its `q[idx]` is 0) and there is no ack in the same cycle: withdraw and return to IDLE with no ret pulse.
  - Ack and disqualification in the same cycle: ack wins.
- **SERVICE**
  - `irq_o = 0`; `irq_cause_o` is held.
  - No nesting: new requests stay pending.
  - `mret_i`: go to RET.
- **RET**
  - `irq_ret_o[idx] = 1` for exactly one cycle, then IDLE.
  - `irq_cause_o` is cleared on entry to IDLE.
- `irq_ack_i` is ignored outside REQ. `mret_i` is ignored outside SERVICE.
- Default arbitration is fixed priority: the lowest index wins.
- Bits of `irq_req_i` at index ≥ `N_SRC` do not exist. Sources whose enable is 0 never win.

## Timing
- Every output resets to 0 and the FSM resets to IDLE. The round-robin pointer resets to 0.
- Reset asserted mid-handshake aborts immediately; no `irq_ret_o` pulse is emitted.
- A qualified request at clock edge k gives `irq_o = 1` after edge k+1: one cycle of latency.
- `irq_ack_i` at edge k gives `irq_o = 0` after edge k+1.
- `mret_i` at edge k gives `irq_ret_o` high during cycle k+1 to k+2. The FSM is back in IDLE after edge k+2.
- The earliest re-arbitration is the cycle after RET. A source still high at that point is re-selected, which gives a minimum 4-cycle turnaround per interrupt.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- `PERIPH_IRQ_ROUND_ROBIN_EN`
  - **Defined:** round-robin arbitration. Search starts at `(last_served+1) mod N_SRC`, and the pointer updates on entry to RET.
  - **Undefined:** fixed priority, lowest index first; no pointer register exists.

## Structure
- Shared package `peripheral_pkg` gains:
  - `IRQ_N_SRC = 16`
  - `IRQ_CAUSE_BASE = 32'h8000_0010`
  - FSM typedef `irq_ctrl_state_t` {IDLE, REQ, SERVICE, RET}
- The existing `*_INT_IDX` constants stay the source of truth for wiring.
- One sub-module, `irq_prio_select`: combinational find-first from a start index. It outputs `valid` and a `$clog2(N_SRC)`-bit index, and the top instantiates it once.

## Test plan
- **Single source:** `irq_req_i[2]=1`, `mie_i[2]=1`, `mstatus_mie_i=1`, then ack and `mret`.
  - `irq_o` rises 1 cycle after the request.
  - `irq_cause_o = 32'h8000_0012`.
  - `irq_ret_o = 16'h0004` for one cycle, 1 cycle after `mret`.
- **Simultaneous requests:** bits 0, 1 and 3 all requested.
  - Fixed priority: cause `32'h8000_0010`, then `11`, then `13` across three handshakes.
  - With `PERIPH_IRQ_ROUND_ROBIN_EN`, after serving 0: order is 1, 3, 0.
- **Masked source:** `mie_i[3]=0` with `irq_req_i[3]=1`.
  - `irq_o` stays 0; setting `mie_i[3]=1` raises it next cycle with cause `32'h8000_0013`.
- **Withdrawal in REQ:** clear `mstatus_mie_i` before ack.
  - `irq_o` drops 1 cycle later, no `irq_ret_o` pulse, `busy_o=0`.
- **No nesting:** source 0 requests during SERVICE of source 2.
  - `irq_o` stays 0 until after RET; source 0 is then presented as `32'h8000_0010`.
- **Reset mid-SERVICE:** pulse `rst_i` asynchronously.
  - All outputs are 0 immediately; a later `mret_i` produces no `irq_ret_o`.
